// File: rtl/multi_clock_divider.sv
// rtl/multi_clock_divider.sv - multi-channel programmable 50% duty clock divider
//
// Ports:
//   clk      : system clock, all state changes on its rising edge
//   rst_n    : asynchronous active-low reset
//   en       : per-channel run enable
//   load     : per-channel strobe capturing div_k into the shadow divisor
//   div_k    : per-channel half-period divisor, channel i at [i*WIDTH +: WIDTH]
//   sync     : strobe phase-aligning every running channel
//   tick     : per-channel one-cycle pulse on rollover (registered)
//   clk_out  : per-channel square wave, period 2*K (registered)
//   pending  : per-channel flag, a loaded divisor awaits activation
module multi_clock_divider #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 28,
  parameter logic [CHANNELS*WIDTH-1:0] RESET_K =
    {WIDTH'(250000000), WIDTH'(25000000), WIDTH'(2500000)}
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] div_k,
  input  logic                      sync,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       clk_out,
  output logic [CHANNELS-1:0]       pending
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] k_act_q, k_act_d;
    logic [WIDTH-1:0] k_shd_q, k_shd_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             clk_q, clk_d;
    logic [WIDTH-1:0] k_in;
    logic [WIDTH-1:0] k_take;
    logic             take;

    assign k_in   = div_k[i*WIDTH +: WIDTH];
    // At a rollover/sync a load in the same cycle beats the older shadow value.
    assign take   = load[i] | pend_q;
    assign k_take = load[i] ? k_in : k_shd_q;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      k_act_d = k_act_q;
      k_shd_d = k_shd_q;
      pend_d  = pend_q;
      tick_d  = 1'b0;
      clk_d   = clk_q;

      if (load[i]) begin
        k_shd_d = k_in;
        pend_d  = 1'b1;
      end

      case (state_q)
        IDLE: begin
          cnt_d = '0;
          clk_d = 1'b0;
          // A fresh load keeps the transfer waiting one more cycle (last value wins).
          if (!load[i] && pend_q) begin
            k_act_d = k_shd_q;
            pend_d  = 1'b0;
          end
          // Entry looks at the divisor that will be active, so a transfer of
          // zero never starts a channel.
          if (en[i] && (k_act_d != '0)) begin
            state_d = RUN;
          end
        end

        RUN: begin
          if (!en[i]) begin
            state_d = IDLE;
            cnt_d   = '0;
            clk_d   = 1'b0;
          end else if (sync || (cnt_q == k_act_q - ONE)) begin
            cnt_d = '0;
            if (take) begin
              k_act_d = k_take;
              pend_d  = 1'b0;
            end
            if (k_act_d == '0) begin
              state_d = IDLE;
              clk_d   = 1'b0;
            end else if (sync) begin
              clk_d = 1'b0;
            end else begin
              tick_d = 1'b1;
              clk_d  = ~clk_q;
            end
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end

        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        k_act_q <= RESET_K[i*WIDTH +: WIDTH];
        k_shd_q <= RESET_K[i*WIDTH +: WIDTH];
        pend_q  <= 1'b0;
        tick_q  <= 1'b0;
        clk_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        k_act_q <= k_act_d;
        k_shd_q <= k_shd_d;
        pend_q  <= pend_d;
        tick_q  <= tick_d;
        clk_q   <= clk_d;
      end
    end

    assign tick[i]    = tick_q;
    assign clk_out[i] = clk_q;
    assign pending[i] = pend_q;
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// tb/tb_multi_clock_divider.sv - randomized bench against a countdown reference model
module tb_multi_clock_divider;

  localparam int CH = 3;
  localparam int W  = 8;
  localparam logic [CH*W-1:0] RK = {8'd7, 8'd5, 8'd3};

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [CH-1:0]   en = '0;
  logic [CH-1:0]   load = '0;
  logic [CH*W-1:0] div_k = '0;
  logic            sync = 1'b0;
  logic [CH-1:0]   tick;
  logic [CH-1:0]   clk_out;
  logic [CH-1:0]   pending;

  multi_clock_divider #(
    .CHANNELS(CH),
    .WIDTH   (W),
    .RESET_K (RK)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .load   (load),
    .div_k  (div_k),
    .sync   (sync),
    .tick   (tick),
    .clk_out(clk_out),
    .pending(pending)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference: each running channel counts down the cycles left in its half-period.
  int rk_val [CH] = '{3, 5, 7};
  bit m_run  [CH];
  int m_rem  [CH];
  int m_kact [CH];
  int m_kshd [CH];
  bit m_pend [CH];
  bit m_lvl  [CH];
  bit m_tick [CH];

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_run[c]  = 1'b0;
      m_rem[c]  = 0;
      m_kact[c] = rk_val[c];
      m_kshd[c] = rk_val[c];
      m_pend[c] = 1'b0;
      m_lvl[c]  = 1'b0;
      m_tick[c] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      bit l;
      int dk;
      l  = load[c];
      dk = int'(div_k[c*W +: W]);
      m_tick[c] = 1'b0;
      if (!m_run[c]) begin
        m_lvl[c] = 1'b0;
        if (l) begin
          m_kshd[c] = dk;
          m_pend[c] = 1'b1;
        end else if (m_pend[c]) begin
          m_kact[c] = m_kshd[c];
          m_pend[c] = 1'b0;
        end
        if (en[c] && m_kact[c] != 0) begin
          m_run[c] = 1'b1;
          m_rem[c] = m_kact[c];
        end
      end else if (!en[c]) begin
        m_run[c] = 1'b0;
        m_lvl[c] = 1'b0;
        if (l) begin
          m_kshd[c] = dk;
          m_pend[c] = 1'b1;
        end
      end else if (sync || m_rem[c] == 1) begin
        if (l) begin
          m_kshd[c] = dk;
          m_kact[c] = dk;
          m_pend[c] = 1'b0;
        end else if (m_pend[c]) begin
          m_kact[c] = m_kshd[c];
          m_pend[c] = 1'b0;
        end
        if (m_kact[c] == 0) begin
          m_run[c] = 1'b0;
          m_lvl[c] = 1'b0;
        end else begin
          m_rem[c] = m_kact[c];
          if (sync) begin
            m_lvl[c] = 1'b0;
          end else begin
            m_tick[c] = 1'b1;
            m_lvl[c]  = ~m_lvl[c];
          end
        end
      end else begin
        m_rem[c]--;
        if (l) begin
          m_kshd[c] = dk;
          m_pend[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all(input string phase);
    logic [CH-1:0] e_tick, e_clk, e_pend;
    for (int c = 0; c < CH; c++) begin
      e_tick[c] = m_tick[c];
      e_clk[c]  = m_lvl[c];
      e_pend[c] = m_pend[c];
    end
    check({phase, ".tick"},    32'(tick),    32'(e_tick));
    check({phase, ".clk_out"}, 32'(clk_out), 32'(e_clk));
    check({phase, ".pending"}, 32'(pending), 32'(e_pend));
  endtask

  function automatic logic [W-1:0] rand_k();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 8'd0;
    if (r < 3)  return 8'd1;
    return W'($urandom_range(2, 9));
  endfunction

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    en    = '1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
      check_all("run");

      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
      end else begin
        rst_n = 1'b1;
      end
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 39) == 0) en[c] = ~en[c];
        load[c] = ($urandom_range(0, 9) == 0);
        div_k[c*W +: W] = rand_k();
      end
      sync = ($urandom_range(0, 29) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multi_clock_divider.md
MULTI_CLOCK_DIVIDER -- requirements
Module: multi_clock_divider

Interface
REQ-001 SHALL have parameter CHANNELS, default 3, meaning the number of independent divider channels (1..16).
REQ-002 SHALL have parameter WIDTH, default 28, meaning the bit width of each half-period divisor K (maximum K is 2^WIDTH-1).
REQ-003 SHALL have parameter RESET_K, default {250000000, 25000000, 2500000} (one WIDTH-bit value per channel, channel 0 in the LSBs), meaning the active K loaded at reset.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port en, input, CHANNELS bits: per-channel run enable.
REQ-007 SHALL have port load, input, CHANNELS bits: per-channel one-cycle strobe that captures a new divisor.
REQ-008 SHALL have port div_k, input, CHANNELS*WIDTH bits: new divisor per channel; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port sync, input, 1 bit: one-cycle strobe that phase-aligns all channels.
REQ-010 SHALL have port tick, output, CHANNELS bits: one-cycle pulse on each channel rollover.
REQ-011 SHALL have port clk_out, output, CHANNELS bits: per-channel 50 % duty square wave with period 2*K clk cycles.
REQ-012 SHALL have port pending, output, CHANNELS bits: high while a loaded divisor is waiting to become active.

Function
REQ-013 SHALL give each channel a two-state FSM, IDLE and RUN, plus a counter cnt (WIDTH bits), an active divisor k_act, a shadow divisor k_shd and a pending flag.
REQ-014 In IDLE, a channel SHALL hold cnt=0, tick=0 and clk_out=0.
REQ-015 A channel SHALL go IDLE->RUN on the cycle after en=1 and k_act!=0 are both sampled; cnt starts from 0.
REQ-016 In RUN, cnt SHALL increment each cycle; when cnt==k_act-1 it SHALL wrap to 0, assert tick for exactly that next cycle and toggle clk_out. The first tick therefore comes K cycles after entering RUN.
REQ-017 Deasserting en SHALL move the channel RUN->IDLE on the next edge, with cnt=0 and clk_out forced to 0 immediately; no tick is issued.
REQ-018 When load[i]=1, k_shd SHALL capture div_k and pending SHALL be set.
REQ-019 If the channel is IDLE, a load SHALL copy the value into k_act on the following cycle and clear pending.
REQ-020 If the channel is in RUN, k_act SHALL update only at the next rollover, and pending SHALL clear at that rollover. This keeps the output free of truncated half-periods.
REQ-021 If load coincides with a rollover, the newly loaded value SHALL take effect at that rollover.
REQ-022 A second load before the transfer SHALL overwrite k_shd; the last value wins.
REQ-023 K=1 SHALL produce a tick every cycle and toggle clk_out every cycle (clk_out = clk/2).
REQ-024 K=0 SHALL be treated as disabled: a channel in RUN that reaches a rollover with K=0 pending SHALL go to IDLE.
REQ-025 On sync=1, every channel in RUN SHALL set cnt=0 and clk_out=0 on the next edge, with no tick.
REQ-026 sync SHALL take priority over a simultaneous rollover; pending transfers SHALL also occur on sync.
REQ-027 Channels SHALL be fully independent except for sync.
REQ-028 tick and clk_out SHALL be registered outputs, with no combinational path from any input.

Reset
REQ-029 While rst_n=0, asynchronously: all channels IDLE, cnt=0, tick=0, clk_out=0, pending=0, k_act=k_shd=RESET_K.
REQ-030 Release of rst_n SHALL take effect on the next clk edge.
REQ-031 Reset asserted mid-period SHALL discard any pending load.

Verification
REQ-032 CHANNELS=1, K=5, en raised at cycle 0 -> tick at cycles 6, 11, 16; clk_out high cycles 6-10, low 11-15.
REQ-033 K=4 running; load div_k=2 at cycle 2 of a period -> current half-period stays 4 cycles, then 2-cycle half-periods; pending high from the load until that rollover.
REQ-034 Three channels with K=3, 5, 7; sync pulsed mid-run -> all clk_out=0 and cnt=0 the next cycle; first post-sync ticks at 3, 5, 7 cycles.
REQ-035 K=1 -> tick constant 1, clk_out alternates every cycle; then load K=0 -> channel IDLE after the next rollover, outputs 0.
REQ-036 en dropped while clk_out=1 -> clk_out=0 next cycle, no tick; en re-raised -> first tick K cycles after re-entering RUN.
REQ-037 rst_n pulsed low mid-period with a load pending -> outputs 0 immediately; after release, channels run at RESET_K values and pending=0.
